// File: rtl/rv_m_pkg.sv
// Shared RV32M definitions: div_op bit indices, divider FSM states, operand width
// and a conditional-negate helper used for signed fixup.
package rv_m_pkg;

  localparam int unsigned XLEN = 32;

  // div_op bit positions, shared with the decoder
  localparam int unsigned DIV_OP_DIV    = 2;
  localparam int unsigned DIV_OP_REM    = 1;
  localparam int unsigned DIV_OP_SIGNED = 0;

  typedef enum logic [1:0] {
    DIV_ST_IDLE = 2'd0,
    DIV_ST_CALC = 2'd1,
    DIV_ST_DONE = 2'd2
  } div_state_e;

  // Two's-complement negate when neg is set
  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + XLEN'(1)) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring step: shift {rem,quo} left, trial-subtract the divisor and
// shift in a quotient 1 when the subtraction does not borrow.
module div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] diff;
  logic            fits;

  // Shifted partial remainder needs one extra bit; the difference always fits in XLEN bits
  always_comb begin
    rem_sh = {rem_i, quo_i[XLEN-1]};
    fits   = (rem_sh >= {1'b0, divisor_i});
    diff   = rem_sh[XLEN-1:0] - divisor_i;
    rem_o  = fits ? diff : rem_sh[XLEN-1:0];
    quo_o  = {quo_i[XLEN-2:0], fits};
  end

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M divider (restoring, one quotient bit per cycle) with valid/ready
// handshakes on both sides and a flush that aborts any in-flight operation.
// Optional build macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow bypass the
// iteration and present the result one cycle after accept.
module div_unit
  import rv_m_pkg::*;
#(
  parameter int unsigned XLEN  = rv_m_pkg::XLEN,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      div_op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  div_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0] rem_q, quo_q, dvsr_q, result_q;
  logic [2:0]      op_q;
  logic            q_neg_q, r_neg_q, div0_q;

  logic            is_signed;
  logic [XLEN-1:0] a_abs, b_abs;
  logic [XLEN-1:0] step_rem, step_quo;
  logic [XLEN-1:0] quo_fix, rem_fix, fin_res;

  div_step #(
    .XLEN(XLEN)
  ) u_step (
    .rem_i    (rem_q),
    .quo_i    (quo_q),
    .divisor_i(dvsr_q),
    .rem_o    (step_rem),
    .quo_o    (step_quo)
  );

  // Operand magnitudes at accept; final sign fixup and result select on the last step
  always_comb begin
    is_signed = div_op[DIV_OP_SIGNED];
    a_abs     = cond_neg(src1, is_signed & src1[XLEN-1]);
    b_abs     = cond_neg(src2, is_signed & src2[XLEN-1]);
    // Divide-by-zero quotient is all ones regardless of signs
    quo_fix   = div0_q ? '1 : cond_neg(step_quo, q_neg_q);
    rem_fix   = cond_neg(step_rem, r_neg_q);
    if (op_q[DIV_OP_DIV])      fin_res = quo_fix;
    else if (op_q[DIV_OP_REM]) fin_res = rem_fix;
    else                       fin_res = '0;
  end

`ifdef DIV_EARLY_OUT_EN
  logic            early;
  logic [XLEN-1:0] early_res;

  // Corner cases resolved directly from the request
  always_comb begin
    logic div0, ovf;
    div0 = (src2 == '0);
    ovf  = is_signed && (src1 == {1'b1, {(XLEN-1){1'b0}}}) && (src2 == '1);
    early = div0 | ovf;
    if (div_op[DIV_OP_DIV])      early_res = div0 ? '1 : src1;
    else if (div_op[DIV_OP_REM]) early_res = div0 ? src1 : '0;
    else                         early_res = '0;
  end
`endif

  // Control FSM and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= DIV_ST_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      result_q <= '0;
      op_q     <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      div0_q   <= 1'b0;
    end else if (flush) begin
      state_q <= DIV_ST_IDLE;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        DIV_ST_IDLE: begin
          if (in_valid) begin
            op_q    <= div_op;
            rem_q   <= '0;
            quo_q   <= a_abs;
            dvsr_q  <= b_abs;
            q_neg_q <= is_signed & (src1[XLEN-1] ^ src2[XLEN-1]);
            r_neg_q <= is_signed & src1[XLEN-1];
            div0_q  <= (src2 == '0);
            state_q <= DIV_ST_CALC;
            cnt_q   <= CNT_W'(XLEN);
`ifdef DIV_EARLY_OUT_EN
            if (early) begin
              state_q  <= DIV_ST_DONE;
              cnt_q    <= '0;
              result_q <= early_res;
            end
`endif
          end
        end
        DIV_ST_CALC: begin
          rem_q <= step_rem;
          quo_q <= step_quo;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q  <= DIV_ST_DONE;
            result_q <= fin_res;
          end
        end
        DIV_ST_DONE: begin
          if (out_ready) state_q <= DIV_ST_IDLE;
        end
        default: state_q <= DIV_ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == DIV_ST_IDLE);
  assign out_valid = (state_q == DIV_ST_DONE);
  assign busy      = (state_q != DIV_ST_IDLE);
  assign result    = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed RV32M cases with literal expectations, then random
// traffic checked every cycle against an arithmetic reference model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid, in_ready, flush, busy, out_valid, out_ready;
  logic [2:0]  div_op;
  logic [31:0] src1, src2, result;

  int total = 0;
  int bad   = 0;

`ifdef DIV_EARLY_OUT_EN
  localparam int CornerLat = 1;
`else
  localparam int CornerLat = 33;
`endif

  always #5 clk = ~clk;

  div_unit u_dut (
    .clk      (clk),
    .resetn   (resetn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .div_op   (div_op),
    .src1     (src1),
    .src2     (src2),
    .flush    (flush),
    .busy     (busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // RISC-V division semantics in plain arithmetic
  function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] q, r;
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 32'h0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'h0;
    end else if (op[0]) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    if (op[2])      return q;
    else if (op[1]) return r;
    else            return 32'h0;
  endfunction

  // Edges from accept until out_valid is visible
  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
    if (b == 32'h0 || (op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 0;
`endif
    return 32;
  endfunction

  // Transaction-level model: one pending result and the cycle it becomes visible
  logic        m_pend = 1'b0;
  int          m_cyc  = 0;
  int          m_done = 0;
  logic [31:0] m_res  = 32'h0;
  int          n_acc  = 0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_pend = 1'b0;
    end else begin
      if (flush) begin
        m_pend = 1'b0;
      end else if (!m_pend) begin
        if (in_valid) begin
          m_pend = 1'b1;
          m_done = m_cyc + 1 + ref_lat(div_op, src1, src2);
          m_res  = ref_div(div_op, src1, src2);
          n_acc++;
        end
      end else if (m_cyc >= m_done && out_ready) begin
        m_pend = 1'b0;
      end
      m_cyc++;
    end
  end

  // Every-cycle compare of handshake outputs and result
  always @(negedge clk) begin
    logic exp_ov;
    exp_ov = m_pend && (m_cyc >= m_done);
    chk("in_ready", in_ready, !m_pend);
    chk("busy", busy, m_pend);
    chk("out_valid", out_valid, exp_ov);
    if (exp_ov) chk("result", result, m_res);
  end

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int k;
    in_valid  = 1'b1;
    div_op    = op;
    src1      = a;
    src2      = b;
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (out_valid) begin
        k = i;
        break;
      end
    end
    chk({name, "_lat"}, k, lat);
    chk({name, "_res"}, result, exp);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return $urandom_range(0, 20);
      4:       return -$urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int seen;
    resetn    = 1'b0;
    in_valid  = 1'b0;
    div_op    = 3'b000;
    src1      = 32'h0;
    src2      = 32'h0;
    flush     = 1'b0;
    out_ready = 1'b1;

    // Reset values
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    #2 resetn = 1'b1;
    @(posedge clk);
    #1;

    // Model pins
    chk("model_divu", ref_div(3'b100, 32'd100, 32'd7), 32'd14);
    chk("model_div_neg", ref_div(3'b101, -32'sd7, 32'd2), 32'hFFFF_FFFD);

    // Directed arithmetic
    run_op("divu", 3'b100, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu", 3'b010, 32'd100, 32'd7, 32'd2, 33);
    run_op("div_neg", 3'b101, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("rem_neg", 3'b011, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("div_ovf", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, CornerLat);
    run_op("rem_ovf", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, CornerLat);
    run_op("div_zero", 3'b101, 32'h1234, 32'h0, 32'hFFFF_FFFF, CornerLat);
    run_op("remu_zero", 3'b010, 32'h1234, 32'h0, 32'h1234, CornerLat);
    run_op("no_sel", 3'b000, 32'd100, 32'd7, 32'h0, 33);
    run_op("both_sel", 3'b110, 32'd100, 32'd7, 32'd14, 33);

    // Back-pressure in DONE
    in_valid  = 1'b1;
    div_op    = 3'b100;
    src1      = 32'd100;
    src2      = 32'd7;
    out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_result", result, 32'd14);
      chk("bp_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    chk("bp_hold_last", out_valid, 1);
    @(negedge clk);
    chk("bp_release_ready", in_ready, 1);
    chk("bp_release_valid", out_valid, 0);
    @(posedge clk);
    #1;

    // Flush in the 10th iteration cycle
    in_valid = 1'b1;
    div_op   = 3'b100;
    src1     = 32'd100;
    src2     = 32'd7;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", busy, 0);
    chk("flush_ready", in_ready, 1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("flush_no_valid", seen, 0);
    @(posedge clk);
    #1;
    run_op("divu_after_flush", 3'b100, 32'd9, 32'd3, 32'd3, 33);

    // Flush beats a request in IDLE
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_idle_busy", busy, 0);
    @(posedge clk);
    #1;

    // Asynchronous reset mid-iteration
    in_valid = 1'b1;
    div_op   = 3'b100;
    src1     = 32'd1000;
    src2     = 32'd3;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_result", result, 0);
    @(negedge clk);
    #2 resetn = 1'b1;
    @(posedge clk);
    #1;
    run_op("remu_after_rst", 3'b010, 32'd10, 32'd3, 32'd1, 33);

    // Random traffic against the model
    n_acc = 0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      in_valid  = ($urandom_range(0, 2) != 0);
      div_op    = 3'($urandom);
      src1      = rand_operand();
      src2      = rand_operand();
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 99) == 0);
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    chk("random_accepts", (n_acc >= 30), 1);
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
